ldm_stm_sequencer: RTL and testbench
====================================

// Module: ldm_stm_sequencer
// PURPOSE
//  Multi-cycle block-transfer engine for LDM/STM. It sits between decode/execute
//   and the three-port register file plus data memory.
//  Walks a 16-bit register list and moves one register per cycle:
//   - load: memory -> regfile write port
//   - store: regfile read port -> memory
//  Stalls the pipeline for the whole transfer.
// PARAMETERS
//  WORD_BYTES  4  address stride per register; must be a power of two
// PORTS
//  clk        in   1   clock
//  reset      in   1   synchronous, active-high
//  start      in   1   request a transfer; sampled only in IDLE
//  is_load    in   1   1=LDM, 0=STM; latched at start
//  up         in   1   1=increment, 0=decrement; latched
//  pre        in   1   1=before (IB/DB), 0=after (IA/DA); latched
//  wback      in   1   base writeback request; latched
//  reglist    in   16  bit i set => transfer Ri; latched
//  base_reg   in   4   base register number; latched
//  base_addr  in   32  base register value; latched
//  rf_rdata   in   32  regfile read data (combinational from rf_ra)
//  mem_rdata  in   32  data memory read data (combinational from mem_addr)
//  busy       out  1   sequencer is in XFER or WB
//  stall      out  1   start | busy; freezes fetch/decode
//  done       out  1   one-cycle completion pulse
//  rf_ra      out  4   regfile read address (STM)
//  rf_we      out  1   regfile write enable
//  rf_wa      out  4   regfile write address
//  rf_wd      out  32  regfile write data
//  mem_addr   out  32  word address; [1:0] forced to 00
//  mem_we     out  1   memory write enable (STM)
//  mem_wdata  out  32  memory write data = rf_rdata
//  pc_load    out  1   LDM loaded R15: redirect pulse
//  pc_value   out  32  new PC; valid when pc_load=1
// BEHAVIOUR
//  States: IDLE -> XFER -> [WB] -> DONE -> IDLE.
//  Reset: IDLE; all outputs 0; rf_ra/rf_wa=0; mem_addr=0. Reset mid-transfer
//   aborts immediately, with no further rf_we or mem_we.
//  IDLE + start: latch all inputs. N = popcount(reglist), 0..16.
//   - N=0: go to DONE with no transfers and no writeback.
//   - N>0: go to XFER.
//  Start address A0, computed mod 2^32:
//   - IA = base
//   - IB = base+4
//   - DA = base-4N+4
//   - DB = base-4N
//  XFER: one register per cycle, lowest-numbered register first, at ascending
//   addresses A0, A0+4, ... There are exactly N XFER cycles. Addresses wrap mod
//   2^32 without error.
//  XFER, STM, register Ri: rf_ra=i, mem_we=1, mem_wdata=rf_rdata.
//   - R15 reads are the PC+8 value supplied by the regfile.
//  XFER, LDM, Ri with i<15: rf_we=1, rf_wa=i, rf_wd=mem_rdata.
//  XFER, LDM, R15: rf_we=0; pc_load=1 and pc_value=mem_rdata with [1:0]
//   cleared, both in the same cycle.
//  Final base = up ? base+4N : base-4N.
//  After the last XFER:
//   - writeback enabled and wback=1 -> WB, else -> DONE.
//  WB: rf_we=1, rf_wa=base_reg, rf_wd=final base. One cycle, then DONE.
//  LDM with base_reg in reglist: writeback is suppressed; the loaded value wins.
//  STM with base_reg in reglist: stores the original base value.
//  WB with base_reg=15: rf_we is suppressed.
//  DONE: done=1 for one cycle, busy=0, then IDLE. A start asserted in DONE is
//   ignored, so the decoder holds start until it sees done.
//  start while busy: ignored. Latched values never change mid-transfer.
//  busy/stall: stall is combinational (start | busy), so the issuing instruction
//   is frozen from its first cycle.
//  Latency: start at cycle 0 -> transfers in cycles 1..N -> WB in cycle N+1
//   (if any) -> done in cycle N+1 (no WB) or N+2 (with WB).
// CONFIGURATION
//  BASE_WB_EN defined: WB state present; wback is honoured per the rules above.
//  BASE_WB_EN undefined: WB state and final-base adder are removed; the wback
//   input is ignored; done always arrives in cycle N+1.
// TESTING
//  1. STMIA, base=0x100, reglist=0x000E (R1-R3):
//     mem_we cycles 1-3 at 0x100, 0x104, 0x108 with rf_ra=1,2,3; done in cycle 4.
//  2. LDMDB, base=0x200, reglist=0x0011, wback=1, BASE_WB_EN defined:
//     loads R0 from 0x1F8 and R4 from 0x1FC; WB writes 0x1F8 to base_reg;
//     done in cycle 4.
//  3. LDMIA, reglist=0x8001, base=0x40, mem[0x44]=0x1003:
//     cycle 1: rf_we for R0.
//     cycle 2: rf_we=0, pc_load=1, pc_value=0x1000.
//  4. reglist=0x0000: no rf_we/mem_we; done in cycle 1; stall high only in
//     cycle 0.
//  5. STMIB, base=0xFFFFFFF8, reglist=0x0003:
//     mem_addr=0xFFFFFFFC, then 0x00000000 (wrap).
//  6. Reset asserted in cycle 2 of a 4-register LDM: no rf_we from cycle 3 on;
//     busy=0; a new start after reset is accepted.

Source files
------------

// File: rtl/ldm_stm_sequencer.sv
// LDM/STM block-transfer engine: walks a 16-bit register list, moving one register per cycle.
// Optional base-register writeback (WB state) is built in when BASE_WB_EN is defined.
module ldm_stm_sequencer #(
  parameter int unsigned WORD_BYTES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_start,
  input  logic        i_is_load,
  input  logic        i_up,
  input  logic        i_pre,
  input  logic        i_wback,
  input  logic [15:0] i_reglist,
  input  logic [3:0]  i_base_reg,
  input  logic [31:0] i_base_addr,
  input  logic [31:0] i_rf_rdata,
  input  logic [31:0] i_mem_rdata,
  output logic        o_busy,
  output logic        o_stall,
  output logic        o_done,
  output logic [3:0]  o_rf_ra,
  output logic        o_rf_we,
  output logic [3:0]  o_rf_wa,
  output logic [31:0] o_rf_wd,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_we,
  output logic [31:0] o_mem_wdata,
  output logic        o_pc_load,
  output logic [31:0] o_pc_value
);

  localparam int unsigned AW = 32;
  localparam int unsigned RW = 4;
  localparam int unsigned LW = 16;
  localparam int unsigned NW = 5;
  localparam logic [AW-1:0] STRIDE = AW'(WORD_BYTES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
`ifdef BASE_WB_EN
    S_WB   = 2'd2,
`endif
    S_DONE = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic          r_is_load;
  logic [LW-1:0] r_list;
  logic [AW-1:0] r_addr;
  logic [NW-1:0] w_n;
  logic [AW-1:0] w_span;
  logic [AW-1:0] w_a0;
  logic [RW-1:0] w_idx;
  logic          w_last;
  logic          w_accept;

  assign w_accept = (r_state == S_IDLE) && i_start;

  always_comb begin : popcount
    w_n = '0;
    for (int i = 0; i < int'(LW); i++) w_n = w_n + NW'(i_reglist[i]);
  end

  assign w_span = AW'(w_n) * STRIDE;

  // Lowest address of the block; transfers always ascend from here
  always_comb begin : start_addr
    case ({i_up, i_pre})
      2'b10:   w_a0 = i_base_addr;
      2'b11:   w_a0 = i_base_addr + STRIDE;
      2'b00:   w_a0 = i_base_addr - w_span + STRIDE;
      default: w_a0 = i_base_addr - w_span;
    endcase
  end

  always_comb begin : lowest_set
    w_idx = '0;
    for (int i = int'(LW) - 1; i >= 0; i--) begin
      if (r_list[i]) w_idx = RW'(i);
    end
  end

  assign w_last = (r_list & (r_list - LW'(1))) == '0;

`ifdef BASE_WB_EN
  logic          r_wb_go;
  logic [RW-1:0] r_base_reg;
  logic [AW-1:0] r_final;

  // A loaded base register wins over the writeback value
  always_ff @(posedge clk) begin : wb_regs
    if (reset) begin
      r_wb_go    <= 1'b0;
      r_base_reg <= '0;
      r_final    <= '0;
    end else if (w_accept) begin
      r_wb_go    <= i_wback && (w_n != '0) && !(i_is_load && i_reglist[i_base_reg]);
      r_base_reg <= i_base_reg;
      r_final    <= i_up ? (i_base_addr + w_span) : (i_base_addr - w_span);
    end
  end
`else
  logic w_unused;
  assign w_unused = ^{i_wback, i_base_reg};
`endif

  always_ff @(posedge clk) begin : state_reg
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk) begin : xfer_regs
    if (reset) begin
      r_is_load <= 1'b0;
      r_list    <= '0;
      r_addr    <= '0;
    end else if (w_accept) begin
      r_is_load <= i_is_load;
      r_list    <= i_reglist;
      r_addr    <= w_a0;
    end else if (r_state == S_XFER) begin
      r_list    <= r_list & (r_list - LW'(1));
      r_addr    <= r_addr + STRIDE;
    end
  end

  // Next state and outputs; reset forces everything quiet in the same cycle
  always_comb begin : next_and_out
    w_next      = r_state;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    o_rf_ra     = '0;
    o_rf_we     = 1'b0;
    o_rf_wa     = '0;
    o_rf_wd     = '0;
    o_mem_addr  = '0;
    o_mem_we    = 1'b0;
    o_mem_wdata = '0;
    o_pc_load   = 1'b0;
    o_pc_value  = '0;
    if (!reset) begin
      case (r_state)
        S_IDLE: begin
          if (i_start) w_next = (w_n == '0) ? S_DONE : S_XFER;
        end
        S_XFER: begin
          o_busy     = 1'b1;
          o_mem_addr = {r_addr[AW-1:2], 2'b00};
          if (!r_is_load) begin
            o_rf_ra     = w_idx;
            o_mem_we    = 1'b1;
            o_mem_wdata = i_rf_rdata;
          end else if (w_idx == RW'(15)) begin
            o_pc_load  = 1'b1;
            o_pc_value = {i_mem_rdata[AW-1:2], 2'b00};
          end else begin
            o_rf_we = 1'b1;
            o_rf_wa = w_idx;
            o_rf_wd = i_mem_rdata;
          end
          if (w_last) begin
`ifdef BASE_WB_EN
            w_next = r_wb_go ? S_WB : S_DONE;
`else
            w_next = S_DONE;
`endif
          end
        end
`ifdef BASE_WB_EN
        S_WB: begin
          o_busy  = 1'b1;
          o_rf_we = (r_base_reg != RW'(15));
          o_rf_wa = r_base_reg;
          o_rf_wd = r_final;
          w_next  = S_DONE;
        end
`endif
        S_DONE: begin
          o_done = 1'b1;
          w_next = S_IDLE;
        end
        default: w_next = S_IDLE;
      endcase
    end
    o_stall = (i_start && !reset) || o_busy;
  end

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Self-checking bench for ldm_stm_sequencer: per-cycle expectations queued at issue, popped each cycle.
module tb_ldm_stm_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, is_load, up, pre, wback;
  logic [15:0] reglist;
  logic [3:0]  base_reg;
  logic [31:0] base_addr;
  logic [31:0] rf_rdata, mem_rdata;
  logic        busy, stall, done, rf_we, mem_we, pc_load;
  logic [3:0]  rf_ra, rf_wa;
  logic [31:0] rf_wd, mem_addr, mem_wdata, pc_value;

  int n_total = 0;
  int n_pass  = 0;
  bit wb_en;

  typedef struct packed {
    logic        busy, stall, done, rf_we, mem_we, pc_load, xfer, idle;
    logic [3:0]  rf_wa, rf_ra;
    logic [31:0] rf_wd, mem_addr, mem_wdata, pc_value;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] rf_fn(input logic [3:0] r);
    if (r == 4'd15) return 32'h0000_2008;
    return 32'h1000_0000 | (32'(r) << 8) | 32'(r);
  endfunction

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a == 32'h44) return 32'h0000_1003;
    return a * 32'h0001_9E37 + 32'h5;
  endfunction

  assign rf_rdata  = rf_fn(rf_ra);
  assign mem_rdata = mem_fn(mem_addr);

  ldm_stm_sequencer dut (
    .clk(clk), .reset(reset), .i_start(start), .i_is_load(is_load), .i_up(up),
    .i_pre(pre), .i_wback(wback), .i_reglist(reglist), .i_base_reg(base_reg),
    .i_base_addr(base_addr), .i_rf_rdata(rf_rdata), .i_mem_rdata(mem_rdata),
    .o_busy(busy), .o_stall(stall), .o_done(done), .o_rf_ra(rf_ra), .o_rf_we(rf_we),
    .o_rf_wa(rf_wa), .o_rf_wd(rf_wd), .o_mem_addr(mem_addr), .o_mem_we(mem_we),
    .o_mem_wdata(mem_wdata), .o_pc_load(pc_load), .o_pc_value(pc_value)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
  endtask

  // Expected per-cycle activity from cycle 1 through the idle cycle after done
  task automatic build(input bit ld, input bit u, input bit p, input bit wb,
                       input logic [15:0] list, input logic [3:0] breg,
                       input logic [31:0] base, input bit hold);
    int n = 0;
    logic [31:0] a;
    exp_t e;
    for (int i = 0; i < 16; i++) if (list[i]) n++;
    case ({u, p})
      2'b10:   a = base;
      2'b11:   a = base + 32'd4;
      2'b00:   a = base - 32'(4 * n) + 32'd4;
      default: a = base - 32'(4 * n);
    endcase
    for (int i = 0; i < 16; i++) begin
      if (list[i]) begin
        e = '0; e.busy = 1'b1; e.stall = 1'b1; e.xfer = 1'b1;
        e.mem_addr = a & 32'hFFFF_FFFC;
        if (!ld) begin
          e.mem_we = 1'b1; e.rf_ra = 4'(i); e.mem_wdata = rf_fn(4'(i));
        end else if (i == 15) begin
          e.pc_load = 1'b1; e.pc_value = mem_fn(e.mem_addr) & 32'hFFFF_FFFC;
        end else begin
          e.rf_we = 1'b1; e.rf_wa = 4'(i); e.rf_wd = mem_fn(e.mem_addr);
        end
        exp_q.push_back(e);
        a = a + 32'd4;
      end
    end
    if (wb_en && wb && n > 0 && !(ld && list[breg])) begin
      e = '0; e.busy = 1'b1; e.stall = 1'b1;
      e.rf_we = (breg != 4'd15); e.rf_wa = breg;
      e.rf_wd = u ? base + 32'(4 * n) : base - 32'(4 * n);
      exp_q.push_back(e);
    end
    e = '0; e.done = 1'b1; e.stall = hold; exp_q.push_back(e);
    e = '0; e.idle = 1'b1; exp_q.push_back(e);
  endtask

  task automatic run(input string tag, input bit ld, input bit u, input bit p, input bit wb,
                     input logic [15:0] list, input logic [3:0] breg,
                     input logic [31:0] base, input bit hold);
    exp_t e;
    int cyc = 1;
    build(ld, u, p, wb, list, breg, base, hold);
    @(posedge clk); #1;
    is_load = ld; up = u; pre = p; wback = wb; reglist = list;
    base_reg = breg; base_addr = base; start = 1'b1;
    #1;
    check({tag, ".c0.stall"}, 32'(stall), 32'd1);
    check({tag, ".c0.busy"},  32'(busy),  32'd0);
    check({tag, ".c0.we"},    32'({rf_we, mem_we}), 32'd0);
    while (exp_q.size() != 0) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      if (!hold || e.idle) start = 1'b0;
      // Scramble the request inputs: they must have been latched
      is_load = 1'($urandom); up = 1'($urandom); pre = 1'($urandom); wback = 1'($urandom);
      reglist = 16'($urandom); base_reg = 4'($urandom); base_addr = $urandom;
      #1;
      check($sformatf("%s.c%0d.busy", tag, cyc),    32'(busy),    32'(e.busy));
      check($sformatf("%s.c%0d.stall", tag, cyc),   32'(stall),   32'(e.stall));
      check($sformatf("%s.c%0d.done", tag, cyc),    32'(done),    32'(e.done));
      check($sformatf("%s.c%0d.rf_we", tag, cyc),   32'(rf_we),   32'(e.rf_we));
      check($sformatf("%s.c%0d.mem_we", tag, cyc),  32'(mem_we),  32'(e.mem_we));
      check($sformatf("%s.c%0d.pc_load", tag, cyc), 32'(pc_load), 32'(e.pc_load));
      if (e.xfer) check($sformatf("%s.c%0d.mem_addr", tag, cyc), mem_addr, e.mem_addr);
      if (e.mem_we) begin
        check($sformatf("%s.c%0d.rf_ra", tag, cyc),     32'(rf_ra), 32'(e.rf_ra));
        check($sformatf("%s.c%0d.mem_wdata", tag, cyc), mem_wdata,  e.mem_wdata);
      end
      if (e.rf_we) begin
        check($sformatf("%s.c%0d.rf_wa", tag, cyc), 32'(rf_wa), 32'(e.rf_wa));
        check($sformatf("%s.c%0d.rf_wd", tag, cyc), rf_wd,      e.rf_wd);
      end
      if (e.pc_load) check($sformatf("%s.c%0d.pc_value", tag, cyc), pc_value, e.pc_value);
      cyc++;
    end
  endtask

  initial begin
`ifdef BASE_WB_EN
    wb_en = 1'b1;
`else
    wb_en = 1'b0;
`endif
    reset = 1'b1; start = 1'b0; is_load = 1'b0; up = 1'b0; pre = 1'b0; wback = 1'b0;
    reglist = '0; base_reg = '0; base_addr = '0;
    @(posedge clk); @(posedge clk); #2;
    check("rst.busy",     32'(busy),     32'd0);
    check("rst.done",     32'(done),     32'd0);
    check("rst.stall",    32'(stall),    32'd0);
    check("rst.we",       32'({rf_we, mem_we, pc_load}), 32'd0);
    check("rst.rf_ra",    32'(rf_ra),    32'd0);
    check("rst.rf_wa",    32'(rf_wa),    32'd0);
    check("rst.mem_addr", mem_addr,      32'd0);
    reset = 1'b0;
    @(posedge clk); #2;
    check("idle.busy", 32'(busy), 32'd0);

    run("stmia",  1'b0, 1'b1, 1'b0, 1'b0, 16'h000E, 4'd13, 32'h0000_0100, 1'b0);
    run("ldmdb",  1'b1, 1'b0, 1'b1, 1'b1, 16'h0011, 4'd2,  32'h0000_0200, 1'b0);
    run("ldm_pc", 1'b1, 1'b1, 1'b0, 1'b0, 16'h8001, 4'd5,  32'h0000_0040, 1'b0);
    run("empty",  1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 4'd3,  32'h0000_0080, 1'b0);
    run("stmib",  1'b0, 1'b1, 1'b1, 1'b0, 16'h0003, 4'd6,  32'hFFFF_FFF8, 1'b0);

    // Reset in cycle 2 of a four-register load
    @(posedge clk); #1;
    is_load = 1'b1; up = 1'b1; pre = 1'b0; wback = 1'b1; reglist = 16'h00F0;
    base_reg = 4'd1; base_addr = 32'h0000_0300; start = 1'b1;
    @(posedge clk); #1; start = 1'b0; #1;
    check("rstmid.c1.rf_we", 32'(rf_we), 32'd1);
    check("rstmid.c1.rf_wa", 32'(rf_wa), 32'd4);
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0; #1;
    check("rstmid.c3.rf_we", 32'(rf_we), 32'd0);
    check("rstmid.c3.busy",  32'(busy),  32'd0);
    @(posedge clk); #2;
    check("rstmid.c4.rf_we", 32'(rf_we), 32'd0);
    check("rstmid.c4.busy",  32'(busy),  32'd0);
    check("rstmid.c4.done",  32'(done),  32'd0);

    run("post_rst", 1'b1, 1'b1, 1'b0, 1'b0, 16'h0003, 4'd9, 32'h0000_0500, 1'b0);
    run("ld_base_in_list", 1'b1, 1'b1, 1'b0, 1'b1, 16'h0006, 4'd1, 32'h0000_0600, 1'b0);
    run("wb_r15",  1'b1, 1'b1, 1'b0, 1'b1, 16'h0003, 4'd15, 32'h0000_0700, 1'b0);
    run("stmda_hold", 1'b0, 1'b0, 1'b0, 1'b0, 16'h8003, 4'd4, 32'h0000_0103, 1'b1);
    run("ldmdb_all", 1'b1, 1'b0, 1'b1, 1'b1, 16'hFFFF, 4'd0, 32'h0000_1000, 1'b0);
    run("stmib_wb", 1'b0, 1'b1, 1'b1, 1'b1, 16'h0100, 4'd3, 32'h0000_0010, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
